// File: rtl/surf_pkg.sv
// -----------------------------------------------------------------------------
// surf_pkg
// Shared types and helpers for the surf_matmul engine:
//   - state_t       : engine FSM states
//   - acc_width()   : accumulator width for an N-term sum of W x W products
//   - idx_width()   : counter/index width for a range of n values (>= 1 bit)
//   - clamp_val()   : wrap or clamp a full-precision sum to W bits
//   - out_of_range(): true when a full-precision sum does not fit in W bits
// Full-precision sums are passed to the helpers sign/zero-extended to EXT_W
// bits so one function body serves every W/SIGNED combination.
// -----------------------------------------------------------------------------
package surf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Width the range helpers operate on; accumulators must be narrower.
    localparam int EXT_W = 128;

    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest representable result value.
    function automatic logic signed [EXT_W-1:0] range_hi(input int w, input bit is_signed);
        logic signed [EXT_W-1:0] one;
        one = {{(EXT_W-1){1'b0}}, 1'b1};
        return is_signed ? (one <<< (w - 1)) - one : (one <<< w) - one;
    endfunction

    // Smallest representable result value (-hi-1 == ~hi for the signed range).
    function automatic logic signed [EXT_W-1:0] range_lo(input int w, input bit is_signed);
        return is_signed ? ~range_hi(w, is_signed) : '0;
    endfunction

    function automatic bit out_of_range(input logic signed [EXT_W-1:0] sum,
                                        input int w, input bit is_signed);
        return (sum > range_hi(w, is_signed)) || (sum < range_lo(w, is_signed));
    endfunction

    // Wrap mode returns the sum unchanged; the caller keeps the low W bits.
    function automatic logic [EXT_W-1:0] clamp_val(input logic signed [EXT_W-1:0] sum,
                                                   input int w, input bit is_signed,
                                                   input bit sat);
        logic signed [EXT_W-1:0] hi;
        logic signed [EXT_W-1:0] lo;
        hi = range_hi(w, is_signed);
        lo = range_lo(w, is_signed);
        if (sat && (sum > hi)) begin
            return hi;
        end else if (sat && (sum < lo)) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/surf_mac.sv
// -----------------------------------------------------------------------------
// surf_mac
// Single multiply-accumulate unit. Multiplies two W-bit operands (signed or
// unsigned per SIGNED) to a 2W-bit product, extends it to AW bits and either
// loads it (i_load=1) or adds it to the registered accumulator.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears accumulator)
//   i_en      : register o_sum into the accumulator on this edge
//   i_load    : start a new sum (ignore the accumulator contents)
//   i_a, i_b  : operands
//   o_sum     : next accumulator value, available in the same cycle so the
//               final term of a dot product can be consumed without waiting
//               for the register
// -----------------------------------------------------------------------------
module surf_mac #(
    parameter int W      = 16,
    parameter int SIGNED = 1,
    parameter int AW     = 2 * W + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    output logic [AW-1:0] o_sum
);

    localparam int PW = 2 * W;

    logic [PW-1:0] w_prod;
    logic [AW-1:0] w_prod_ext;
    logic [AW-1:0] r_acc;

    // Operands are widened to the product width before multiplying so the
    // full 2W-bit product is kept.
    if (SIGNED != 0) begin : g_signed
        assign w_prod     = $signed({{W{i_a[W-1]}}, i_a}) * $signed({{W{i_b[W-1]}}, i_b});
        assign w_prod_ext = {{(AW-PW){w_prod[PW-1]}}, w_prod};
    end else begin : g_unsigned
        assign w_prod     = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
        assign w_prod_ext = {{(AW-PW){1'b0}}, w_prod};
    end

    assign o_sum = (i_load ? '0 : r_acc) + w_prod_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/surf_matmul.sv
// -----------------------------------------------------------------------------
// surf_matmul
// Sequential N x N matrix multiply C = A * B using one MAC per cycle.
// Operands are captured on acceptance; C(i,j) is written when the last term
// (k = N-1) of its dot product is accumulated. Results either wrap to W bits
// or saturate (SAT), and ovf flags any element whose exact sum did not fit.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a, b                 : N*N*W operand matrices, row-major, (0,0) in MSBs
//   out_valid / out_ready: result handshake; c and ovf held while waiting
//   c                    : N*N*W result matrix, same packing as a and b
//   ovf                  : some element of c overflowed W bits
// Latency: out_valid rises N^3 edges after the accepting edge.
// -----------------------------------------------------------------------------
module surf_matmul
    import surf_pkg::*;
#(
    parameter int N      = 2,
    parameter int W      = 16,
    parameter int SIGNED = 1,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] a,
    input  logic [N*N*W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N*W-1:0] c,
    output logic             ovf
);

    localparam int NN = N * N;
    localparam int AW = acc_width(N, W);
    localparam int CW = idx_width(N);
    localparam int EW = idx_width(NN);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_next;

    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;
    logic [CW-1:0] r_k;
    logic [W-1:0]  r_a [NN];
    logic [W-1:0]  r_b [NN];
    logic [W-1:0]  r_c [NN];
    logic          r_ovf;

    logic          w_accept;
    logic          w_mac_en;
    logic          w_last;
    logic [EW-1:0] w_a_idx;
    logic [EW-1:0] w_b_idx;
    logic [EW-1:0] w_c_idx;
    logic [AW-1:0] w_sum;
    logic          w_sign_fill;
    logic [EXT_W-1:0] w_sum_ext;
    logic [W-1:0]  w_res_val;
    logic          w_res_ovf;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);

    // NOTE: every output of this block is given a default before the case
    // statement, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_mac_en     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_mac_en = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    // NOTE: the operand registers are left without reset: they are always
    // loaded on acceptance before any MAC reads them, so a reset would only
    // add fan-out on rst.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int e = 0; e < NN; e++) begin
                r_a[e] <= a[(NN-1-e)*W +: W];
                r_b[e] <= b[(NN-1-e)*W +: W];
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC: a(i,k) * b(k,j), new sum whenever k restarts at 0
    // ------------------------------------------------------------------
    assign w_a_idx = EW'(32'(r_i) * N + 32'(r_k));
    assign w_b_idx = EW'(32'(r_k) * N + 32'(r_j));
    assign w_c_idx = EW'(32'(r_i) * N + 32'(r_j));

    surf_mac #(
        .W      (W),
        .SIGNED (SIGNED),
        .AW     (AW)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_mac_en),
        .i_load (r_k == '0),
        .i_a    (r_a[w_a_idx]),
        .i_b    (r_b[w_b_idx]),
        .o_sum  (w_sum)
    );

    // Exact sum in the helpers' common width, then wrap/clamp and range check.
    assign w_sign_fill = (SIGNED != 0) && w_sum[AW-1];
    assign w_sum_ext   = {{(EXT_W-AW){w_sign_fill}}, w_sum};
    assign w_res_val   = W'(clamp_val(w_sum_ext, W, SIGNED != 0, SAT != 0));
    assign w_res_ovf   = out_of_range(w_sum_ext, W, SIGNED != 0);

    // ------------------------------------------------------------------
    // Loop counters, result matrix and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_ovf <= 1'b0;
            for (int e = 0; e < NN; e++) begin
                r_c[e] <= '0;
            end
        end else if (w_accept) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_ovf <= 1'b0;
        end else if (w_mac_en) begin
            if (r_k == LAST) begin
                r_c[w_c_idx] <= w_res_val;
                r_ovf        <= r_ovf | w_res_ovf;
                r_k          <= '0;
                if (r_j == LAST) begin
                    r_j <= '0;
                    r_i <= (r_i == LAST) ? '0 : r_i + CW'(1);
                end else begin
                    r_j <= r_j + CW'(1);
                end
            end else begin
                r_k <= r_k + CW'(1);
            end
        end
    end

    for (genvar e = 0; e < NN; e++) begin : g_pack
        assign c[(NN-1-e)*W +: W] = r_c[e];
    end

    assign ovf = r_ovf;

endmodule

// File: tb/tb_surf_matmul.sv
// -----------------------------------------------------------------------------
// tb_surf_matmul
// Three engines side by side (W=16 throughout):
//   d0: N=2 signed, wrap     d1: N=2 signed, saturate     d2: N=3 unsigned, wrap
// Expected C and ovf come from a plain integer matrix product in the bench.
// -----------------------------------------------------------------------------
module tb_surf_matmul;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   ovf_w;
    logic [63:0]  a0, b0, c0, a1, b1, c1;
    logic [143:0] a2, b2, c2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    surf_matmul #(.N(2), .W(16), .SIGNED(1), .SAT(0)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a0), .b(b0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .c(c0), .ovf(ovf_w[0]));

    surf_matmul #(.N(2), .W(16), .SIGNED(1), .SAT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a1), .b(b1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .c(c1), .ovf(ovf_w[1]));

    surf_matmul #(.N(3), .W(16), .SIGNED(0), .SAT(0)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a2), .b(b2), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .c(c2), .ovf(ovf_w[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dim(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic logic [15:0] get_c(input int d, input int e);
        case (d)
            0:       return c0[(3-e)*16 +: 16];
            1:       return c1[(3-e)*16 +: 16];
            default: return c2[(8-e)*16 +: 16];
        endcase
    endfunction

    // Reference: exact integer dot products, then wrap or clamp to 16 bits.
    task automatic model(input int d, input int A[9], input int B[9],
                         output logic [15:0] exp[9], output logic exp_ovf);
        int n;
        bit sgn;
        longint s, hi, lo, x, y;
        logic [15:0] ea, eb;
        n   = dim(d);
        sgn = (d != 2);
        hi  = sgn ? 64'sd32767 : 64'sd65535;
        lo  = sgn ? -64'sd32768 : 64'sd0;
        exp_ovf = 1'b0;
        for (int e = 0; e < 9; e++) exp[e] = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    ea = A[i*n+k][15:0];
                    eb = B[k*n+j][15:0];
                    x  = sgn ? longint'($signed(ea)) : longint'(ea);
                    y  = sgn ? longint'($signed(eb)) : longint'(eb);
                    s += x * y;
                end
                if (s > hi || s < lo) exp_ovf = 1'b1;
                if (d == 1 && s > hi)      exp[i*n+j] = hi[15:0];
                else if (d == 1 && s < lo) exp[i*n+j] = lo[15:0];
                else                       exp[i*n+j] = s[15:0];
            end
        end
    endtask

    task automatic load_operands(input int d, input int A[9], input int B[9]);
        logic [143:0] pa, pb;
        int n;
        n  = dim(d);
        pa = '0;
        pb = '0;
        for (int e = 0; e < n*n; e++) begin
            pa[(n*n-1-e)*16 +: 16] = A[e][15:0];
            pb[(n*n-1-e)*16 +: 16] = B[e][15:0];
        end
        case (d)
            0:       begin a0 = pa[63:0]; b0 = pb[63:0]; end
            1:       begin a1 = pa[63:0]; b1 = pb[63:0]; end
            default: begin a2 = pa;       b2 = pb;       end
        endcase
    endtask

    // One full transaction: accept, latency, result, optional backpressure,
    // hand-off. 'early' raises out_ready while the engine is still computing.
    task automatic run_op(input int d, input int A[9], input int B[9],
                          input int bp, input bit early);
        logic [15:0] exp [9];
        logic        exp_ovf;
        int          n, cyc;
        n = dim(d);
        model(d, A, B, exp, exp_ovf);
        load_operands(d, A, B);
        @(negedge clk);
        in_valid[d] = 1'b1;
        check($sformatf("d%0d in_ready idle", d), 64'(in_ready[d]), 64'd1);
        @(posedge clk);
        #1;
        check($sformatf("d%0d in_ready calc", d), 64'(in_ready[d]), 64'd0);
        @(negedge clk);
        in_valid[d] = 1'b0;
        if (early) out_ready[d] = 1'b1;
        // Scramble inputs: the engine must work from its captured copy.
        load_operands(d, B, A);
        cyc = 0;
        while (out_valid[d] !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("d%0d latency", d), 64'(cyc), 64'(n*n*n));
        for (int e = 0; e < n*n; e++)
            check($sformatf("d%0d c[%0d]", d, e), 64'(get_c(d, e)), 64'(exp[e]));
        check($sformatf("d%0d ovf", d), 64'(ovf_w[d]), 64'(exp_ovf));
        if (!early) begin
            for (int t = 0; t < bp; t++) begin
                @(posedge clk);
                #1;
                check($sformatf("d%0d bp out_valid", d), 64'(out_valid[d]), 64'd1);
                check($sformatf("d%0d bp in_ready", d), 64'(in_ready[d]), 64'd0);
                check($sformatf("d%0d bp ovf", d), 64'(ovf_w[d]), 64'(exp_ovf));
                for (int e = 0; e < n*n; e++)
                    check($sformatf("d%0d bp c[%0d]", d, e), 64'(get_c(d, e)), 64'(exp[e]));
            end
            @(negedge clk);
            out_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        check($sformatf("d%0d in_ready after", d), 64'(in_ready[d]), 64'd1);
        check($sformatf("d%0d out_valid after", d), 64'(out_valid[d]), 64'd0);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    function automatic int rand_elem(input int d, input int mode);
        int ext_v [4];
        ext_v = '{32'h7FFF, 32'h8000, 32'hFFFF, 0};
        case (mode)
            0:       return (d == 2) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 16)) - 8;
            1:       return int'($urandom_range(0, 65535));
            default: return ext_v[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        int A[9], B[9];
        int mode, bp;
        bit early, seen;

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd7);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset ovf", 64'(ovf_w), 64'd0);
        check("reset c", 64'(|{c0, c1, c2}), 64'd0);
        rst = 1'b0;

        // Basic product with latency, then signed operands.
        A = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        B = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        run_op(0, A, B, 0, 1'b0);
        A = '{-1, 2, 3, -4, 0, 0, 0, 0, 0};
        B = '{5, -6, 7, 8, 0, 0, 0, 0, 0};
        run_op(0, A, B, 0, 1'b0);

        // Overflow: wrap keeps 0x0002, saturate clamps to 0x7FFF; both flag ovf.
        A = '{32767, 32767, 0, 0, 0, 0, 0, 0, 0};
        B = '{32767, 0, 32767, 0, 0, 0, 0, 0, 0};
        run_op(0, A, B, 0, 1'b0);
        run_op(1, A, B, 5, 1'b0);
        // Clean operation after an overflow clears ovf; out_ready held early.
        A = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        B = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        run_op(1, A, B, 0, 1'b1);

        // Larger unsigned matrix: identity times 1..9.
        A = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        B = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_op(2, A, B, 2, 1'b0);

        // Reset ten cycles into CALC discards the result.
        load_operands(2, B, A);
        @(negedge clk);
        in_valid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst out_valid", 64'(out_valid[2]), 64'd0);
        check("rst in_ready", 64'(in_ready[2]), 64'd1);
        check("rst c", 64'(|c2), 64'd0);
        check("rst ovf", 64'(ovf_w[2]), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid[2] === 1'b1) seen = 1'b1;
        end
        check("rst no result", 64'(seen), 64'd0);

        // Randomized transactions on every engine.
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < 3; d++) begin
                mode  = int'($urandom_range(0, 2));
                for (int e = 0; e < 9; e++) begin
                    A[e] = rand_elem(d, mode);
                    B[e] = rand_elem(d, mode);
                end
                bp    = int'($urandom_range(0, 3));
                early = (bp == 0) && ($urandom_range(0, 1) == 1);
                run_op(d, A, B, bp, early);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/surf_matmul.md
# surf_matmul

Sequential, parametrised N×N matrix-multiply engine, C = A·B, generalising the fixed combinational 2×2 surfboard product to arbitrary dimension with a valid/ready handshake, a selectable wrap/saturate result mode and an overflow flag. It sits between an operand source and a result sink and uses a single multiply-accumulate unit, trading latency for area.

## Interface
- N, 2: matrix dimension, at least 1.
- W, 16: element width in bits, at least 2.
- SIGNED, 1: 1 means two's-complement operands and results; 0 means unsigned.
- SAT, 0: 0 wraps results to the low W bits; 1 clamps results to the W-bit range.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B operands are presented.
- in_ready  output  1  engine can accept operands.
- a  input  N\*N\*W  matrix A, row-major.
- b  input  N\*N\*W  matrix B, row-major.
- out_valid  output  1  result C is valid.
- out_ready  input  1  sink accepts C.
- c  output  N\*N\*W  matrix C, row-major, registered.
- ovf  output  1  at least one element of the current C overflowed W bits.

## Operation
- Packing: element (i,j) occupies bits [((N\*N-1)-(i\*N+j))\*W +: W], so element (0,0) sits in the MSBs.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a and b into internal registers, clear ovf, clear counters, go to CALC.
  - CALC: one MAC per cycle. Loop order is k innermost, then j, then i. When k=0, acc = a(i,k)·b(k,j); otherwise acc += a(i,k)·b(k,j).
    - When k=N-1, write the result of the full sum into c(i,j).
    - After element (N-1,N-1) is written, go to DONE.
  - DONE: out_valid=1; c and ovf are held stable. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE, so there is no overlap between operations. Operands may change freely after acceptance.
- Arithmetic:
  - Product width is 2W; accumulator width is 2W+clog2(N)+1, so the accumulator cannot overflow.
  - Operands are sign- or zero-extended according to SIGNED.
- Result of each element, based on the full-precision sum:
  - SAT=0: low W bits (identical to summing truncated products).
  - SAT=1: clamp to [-2^(W-1), 2^(W-1)-1] if SIGNED, else [0, 2^W-1].
- ovf: sticky per matrix. It is set if any full sum lies outside the W-bit range, in either mode.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, c=0, ovf=0, counters=0, accumulator=0.
- Acceptance occurs at rising edge t0 when in_valid and in_ready are both 1.
  - CALC occupies N³ cycles.
  - out_valid rises after edge t0+N³ (8 cycles for N=2, 27 for N=3).
- out_valid stays high until the edge with out_ready=1. out_valid and c must not change while out_valid=1 and out_ready=0.
- Hand-off timing:
  - in_ready returns to 1 in the cycle after the output handshake.
  - Minimum issue interval is N³+2 cycles.
- out_ready=1 before out_valid has no effect.
- in_valid during CALC or DONE is ignored; the upstream source must hold it.
- Reset asserted mid-CALC or mid-DONE immediately aborts: outputs take their reset values and the partial result is discarded.

## Structure
- Package surf_pkg holds:
  - the FSM state enum (IDLE, CALC, DONE);
  - helper functions for accumulator width (2W+clog2(N)+1);
  - the clamp/range-check function, parametrised on W and SIGNED.
- Sub-module surf_mac: signed/unsigned multiply with accumulate/load select and registered accumulator output. It is instantiated once.
- The top level contains the FSM, the i/j/k counters, the operand registers, the result register and the ovf logic.

## Test plan
- Basic product (N=2, W=16, SIGNED=1, SAT=0): A=[1,2,3,4], B=[5,6,7,8] -> c=[19,22,43,50], ovf=0, out_valid exactly 8 cycles after acceptance.
- Signed operands: A=[-1,2,3,-4], B=[5,-6,7,8] -> c=[9,22,-13,-50], ovf=0.
- Overflow, wrap mode (SAT=0): A=[32767,32767,0,0], B=[32767,0,32767,0] -> c=[2,0,0,0] (0x7FFE0002 truncated), ovf=1.
- Overflow, saturate mode (SAT=1): same operands -> c=[32767,0,0,0], ovf=1. The next operation without overflow clears ovf.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> c and out_valid stable, in_ready=0 throughout. Then out_ready=1 -> in_ready=1 in the next cycle.
- Reset and larger matrix:
  - N=3, SIGNED=0, A=identity, B=[1..9] -> c=[1..9] after 27 cycles.
  - rst pulsed at CALC cycle 10 -> out_valid=0, in_ready=1, c=0, and no result is emitted.
